// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit with a 2-entry prefetch FIFO. It issues word reads to
// the instruction memory, queues {pc, instr} pairs for decode, and handles
// branch redirects from execute, including discarding a response that is
// already in flight when the redirect arrives.
//
// Parameters
//   RESET_PC       first fetch address after reset
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   imem_req_o     instruction memory read request
//   imem_addr_o    word-aligned read address, stable while the request is open
//   imem_ack_i     read completes this cycle
//   imem_data_i    read data, sampled when imem_ack_i is high
//   redirect_i     branch-taken redirect, highest priority event
//   redirect_pc_i  redirect target (low two bits ignored)
//   instr_valid_o  FIFO head holds an instruction for decode
//   instr_ready_i  decode accepts the head instruction
//   instr_o        instruction word at the FIFO head (0 when empty)
//   opcode_o       instr_o[6:0]
//   pc_o           PC of instr_o (0 when empty)
//   illegal_o      head opcode is not in the supported set
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;     // next address to fetch on the live path
    logic [31:0] req_addr;     // address of the request currently on the bus
    logic        req_active;

    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        fifo_valid;
    logic        pop;
    logic        push;
    logic [1:0]  count_after_pop;
    logic [1:0]  count_next;
    logic [31:0] redirect_target;
    logic [31:0] fetch_pc_inc;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic        opcode_supported;

    // -------------------------------------------------------------------------
    // Next-state helpers
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_valid      = (count != 2'd0);
        pop             = fifo_valid & instr_ready_i;
        // A response returning alongside a redirect belongs to the old path.
        push            = (state == StReq) & imem_ack_i & ~redirect_i;
        count_after_pop = count - {1'b0, pop};
        count_next      = count_after_pop + {1'b0, push};
        redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
        fetch_pc_inc    = fetch_pc + 32'd4;
    end

    // -------------------------------------------------------------------------
    // Control FSM, fetch PC and FIFO storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= StIdle;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            req_active <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else if (redirect_i) begin
            // Flush wins over any pop or push this cycle.
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            fetch_pc <= redirect_target;
            unique case (state)
                StIdle: begin
                    state <= StIdle;
                end
                StReq: begin
                    if (imem_ack_i) begin
                        state      <= StIdle;
                        req_active <= 1'b0;
                    end else begin
                        // Keep the old request on the bus until it completes.
                        state <= StDrop;
                    end
                end
                StDrop: begin
                    if (imem_ack_i) begin
                        state      <= StIdle;
                        req_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= StIdle;
                    req_active <= 1'b0;
                end
            endcase
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= fetch_pc;
                fifo_instr[wr_ptr] <= imem_data_i;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;

            unique case (state)
                StIdle: begin
                    // Only start a fetch that is guaranteed a free slot.
                    if (count_after_pop != 2'd2) begin
                        state      <= StReq;
                        req_active <= 1'b1;
                        req_addr   <= fetch_pc;
                    end
                end
                StReq: begin
                    if (imem_ack_i) begin
                        fetch_pc <= fetch_pc_inc;
                        if (count_next != 2'd2) begin
                            req_addr <= fetch_pc_inc;
                        end else begin
                            state      <= StIdle;
                            req_active <= 1'b0;
                        end
                    end
                end
                StDrop: begin
                    if (imem_ack_i) begin
                        state      <= StIdle;
                        req_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= StIdle;
                    req_active <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        head_pc    = fifo_pc[rd_ptr];
        head_instr = fifo_instr[rd_ptr];

        imem_req_o    = req_active;
        imem_addr_o   = req_addr;
        instr_valid_o = fifo_valid;
        instr_o       = fifo_valid ? head_instr : 32'h0;
        pc_o          = fifo_valid ? head_pc : 32'h0;
        opcode_o      = instr_o[6:0];

        case (opcode_o)
            7'b0010011,  // OP-IMM
            7'b0110011,  // OP
            7'b1100011,  // BRANCH
            7'b0000011,  // LOAD
            7'b0100011,  // STORE
            7'b1010111:  // OP-V
                opcode_supported = 1'b1;
            default:
                opcode_supported = 1'b0;
        endcase

        illegal_o = fifo_valid & ~opcode_supported;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port imem_req_o, output, 1 bit: instruction-memory read request.
REQ-005 The module SHALL have port imem_addr_o, output, 32 bits: word-aligned read address.
REQ-006 The module SHALL have port imem_ack_i, input, 1 bit: read completes; data is valid in this cycle.
REQ-007 The module SHALL have port imem_data_i, input, 32 bits: instruction word, sampled when imem_ack_i=1.
REQ-008 The module SHALL have port redirect_i, input, 1 bit: branch-taken redirect from execute.
REQ-009 The module SHALL have port redirect_pc_i, input, 32 bits: redirect target.
REQ-010 The module SHALL have port instr_valid_o, output, 1 bit: instruction available to decode.
REQ-011 The module SHALL have port instr_ready_i, input, 1 bit: decode accepts the instruction.
REQ-012 The module SHALL have port instr_o, output, 32 bits: instruction word at FIFO head.
REQ-013 The module SHALL have port opcode_o, output, 7 bits: instr_o[6:0], feeding the decoder opcode input.
REQ-014 The module SHALL have port pc_o, output, 32 bits: PC of instr_o.
REQ-015 The module SHALL have port illegal_o, output, 1 bit: head opcode is outside the supported set.

Function
REQ-016 States SHALL be IDLE (no request outstanding), REQ (request outstanding) and DROP (outstanding response to be discarded).
REQ-017 A 2-entry FIFO SHALL buffer {pc, instr}; instr_valid_o=1 iff the FIFO is non-empty; handshake completes when instr_valid_o & instr_ready_i, popping one entry.
REQ-018 IDLE->REQ when FIFO occupancy after this cycle's pop is below 2; imem_req_o=1 and imem_addr_o=fetch_pc are driven in REQ and DROP and held stable until imem_ack_i.
REQ-019 In REQ with imem_ack_i=1: push {fetch_pc, imem_data_i}; fetch_pc += 4 (mod 2^32); next state REQ if space remains, else IDLE.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; push SHALL never be issued into a full FIFO (guaranteed by REQ-018).
REQ-021 redirect_i=1 SHALL take priority over every other event: FIFO flushed, fetch_pc := redirect_pc_i, and any pop that cycle is ignored (instr_valid_o=0 next cycle).
REQ-022 Redirect in REQ without ack -> DROP; redirect in REQ with ack -> data discarded, next state IDLE; redirect in IDLE or DROP -> state unchanged apart from fetch_pc.
REQ-023 In DROP, imem_req_o=1 continues with the old address; on imem_ack_i the data is discarded and next state is IDLE; imem_addr_o switches to the new fetch_pc only on the first request after DROP.
REQ-024 illegal_o SHALL be 1 when instr_valid_o=1 and opcode_o is not one of 0010011, 0110011, 1100011, 0000011, 0100011, 1010111; otherwise 0; combinational from the FIFO head.
REQ-025 Head-to-output latency SHALL be 1 cycle: an instruction acked in cycle N is presented in cycle N+1 if the FIFO was empty.
REQ-026 The low two bits of redirect_pc_i SHALL be forced to 0 internally.

Reset
REQ-027 On rst_i=1 at a clock edge: state IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req_o=0, instr_valid_o=0, illegal_o=0, instr_o/pc_o=0; this overrides redirect_i and imem_ack_i in the same cycle.
REQ-028 Reset during REQ or DROP SHALL abandon the outstanding request; a late imem_ack_i in IDLE SHALL be ignored.
REQ-029 The first imem_req_o after reset release SHALL assert in the cycle after rst_i falls, with address RESET_PC.

Verification
REQ-030 Reset, ready=1, ack every cycle, words 0x00500093, 0x002081B3 -> pc_o 0x0, 0x4 back-to-back, opcode_o 0010011 then 0110011, illegal_o=0.
REQ-031 ready=0, ack always 1 -> exactly 2 pushes (pc 0x0, 0x4), then imem_req_o=0; set ready=1 -> fetch resumes at 0x8.
REQ-032 Redirect to 0x100 while a REQ at 0x8 is outstanding, ack after 3 cycles -> that data dropped, FIFO empty, next request address 0x100, next pc_o 0x100.
REQ-033 Redirect and handshake in the same cycle with 2 entries queued -> both entries gone, instr_valid_o=0 next cycle.
REQ-034 Word 0x0000007F fetched -> instr_valid_o=1, opcode_o=1111111, illegal_o=1.
REQ-035 rst_i in DROP, then ack pulse after release -> ack ignored, first request at RESET_PC.
